// File: rtl/quiz_score_accumulator.sv
// Quiz scoring stage feeding the letter-grade display decoder: counts NUM_Q answers,
// accumulates a saturating 9-bit score. Optional macro QUIZ_PENALTY_EN: wrong answers cost 1 point.
module quiz_score_accumulator #(
    parameter int NUM_Q     = 10,
    parameter int MAX_SCORE = 511
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       ans_valid_i,
    input  logic       ans_correct_i,
    input  logic [3:0] ans_pts_i,
    output logic [8:0] score_o,
    output logic       disp_en_o,
    output logic       disp_clear_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [5:0] q_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [9:0] MAX10 = 10'(MAX_SCORE);
    localparam logic [5:0] LAST  = 6'(NUM_Q);

    state_t     state_q, state_d;
    logic [8:0] score_q, score_d;
    logic [5:0] q_count_q, q_count_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       disp_clear_q, disp_clear_d;
    logic       disp_en_q;

    logic [9:0] sum;
    logic [5:0] cnt_inc;
    logic [8:0] score_ans;

    // Sum is one bit wider than the score so the clamp sees the true total.
    assign sum     = {1'b0, score_q} + {6'd0, ans_pts_i};
    assign cnt_inc = q_count_q + 6'd1;

    always_comb begin
        score_ans = score_q;
        if (ans_correct_i) begin
            score_ans = (sum > MAX10) ? MAX10[8:0] : sum[8:0];
        end else begin
`ifdef QUIZ_PENALTY_EN
            score_ans = (score_q == 9'd0) ? 9'd0 : score_q - 9'd1;
`else
            score_ans = score_q;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        q_count_d = q_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_RUN;
                    score_d   = 9'd0;
                    q_count_d = 6'd0;
                end
            end
            S_RUN: begin
                // A start in the same cycle as an answer wins; the answer is dropped.
                if (start_i) begin
                    score_d   = 9'd0;
                    q_count_d = 6'd0;
                end else if (ans_valid_i) begin
                    q_count_d = cnt_inc;
                    score_d   = score_ans;
                    if (cnt_inc == LAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    state_d   = S_RUN;
                    score_d   = 9'd0;
                    q_count_d = 6'd0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                score_d   = 9'd0;
                q_count_d = 6'd0;
            end
        endcase
        busy_d       = (state_d == S_RUN);
        done_d       = (state_d == S_DONE);
        disp_clear_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            score_q      <= 9'd0;
            q_count_q    <= 6'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            disp_clear_q <= 1'b1;
            disp_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            q_count_q    <= q_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            disp_clear_q <= disp_clear_d;
            disp_en_q    <= 1'b1;
        end
    end

    assign score_o      = score_q;
    assign q_count_o    = q_count_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign disp_clear_o = disp_clear_q;
    assign disp_en_o    = disp_en_q;

endmodule

// File: tb/tb_quiz_score_accumulator.sv
// Directed bench: default instance (NUM_Q=10, MAX_SCORE=511) plus a MAX_SCORE=100 instance on shared inputs.
module tb_quiz_score_accumulator;

    logic       clk_i = 1'b0;
    logic       reset_i, start_i, ans_valid_i, ans_correct_i;
    logic [3:0] ans_pts_i;
    logic [8:0] score_o, score2_o;
    logic       disp_en_o, disp_clear_o, busy_o, done_o;
    logic       disp_en2_o, disp_clear2_o, busy2_o, done2_o;
    logic [5:0] q_count_o, q_count2_o;

    int total = 0;
    int bad   = 0;

`ifdef QUIZ_PENALTY_EN
    localparam int MIX_SCORE = 56;
`else
    localparam int MIX_SCORE = 60;
`endif

    always #5 clk_i = ~clk_i;

    quiz_score_accumulator #(.NUM_Q(10), .MAX_SCORE(511)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .ans_valid_i(ans_valid_i), .ans_correct_i(ans_correct_i), .ans_pts_i(ans_pts_i),
        .score_o(score_o), .disp_en_o(disp_en_o), .disp_clear_o(disp_clear_o),
        .busy_o(busy_o), .done_o(done_o), .q_count_o(q_count_o)
    );

    quiz_score_accumulator #(.NUM_Q(10), .MAX_SCORE(100)) dut_sat (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .ans_valid_i(ans_valid_i), .ans_correct_i(ans_correct_i), .ans_pts_i(ans_pts_i),
        .score_o(score2_o), .disp_en_o(disp_en2_o), .disp_clear_o(disp_clear2_o),
        .busy_o(busy2_o), .done_o(done2_o), .q_count_o(q_count2_o)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic answer(input logic correct, input logic [3:0] pts);
        ans_valid_i   = 1'b1;
        ans_correct_i = correct;
        ans_pts_i     = pts;
        tick();
        ans_valid_i   = 1'b0;
        ans_correct_i = 1'b0;
        ans_pts_i     = 4'd0;
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; ans_valid_i = 1'b0;
        ans_correct_i = 1'b0; ans_pts_i = 4'd0;
        tick(); tick();
        chk("rst_score", score_o, 0);
        chk("rst_qcnt", q_count_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_clear", disp_clear_o, 1);
        chk("rst_en", disp_en_o, 0);

        reset_i = 1'b0;
        tick();
        chk("en_after_rst", disp_en_o, 1);
        chk("idle_clear", disp_clear_o, 1);

        answer(1'b1, 4'd9);
        chk("idle_ign_qcnt", q_count_o, 0);
        chk("idle_ign_busy", busy_o, 0);

        // 10 correct x 9 points
        pulse_start();
        chk("start_busy", busy_o, 1);
        chk("start_score", score_o, 0);
        for (int i = 0; i < 9; i++) answer(1'b1, 4'd9);
        chk("a9_qcnt", q_count_o, 9);
        chk("a9_done", done_o, 0);
        chk("a9_clear", disp_clear_o, 1);
        answer(1'b1, 4'd9);
        chk("a10_score", score_o, 90);
        chk("a10_qcnt", q_count_o, 10);
        chk("a10_done", done_o, 1);
        chk("a10_busy", busy_o, 0);
        chk("a10_clear", disp_clear_o, 0);

        // 6 correct x 10, 4 incorrect, interleaved
        pulse_start();
        chk("mix_start_done", done_o, 0);
        chk("mix_start_score", score_o, 0);
        answer(1'b1, 4'd10); answer(1'b0, 4'd10); answer(1'b1, 4'd10);
        answer(1'b1, 4'd10); answer(1'b0, 4'd10); answer(1'b1, 4'd10);
        answer(1'b0, 4'd10); answer(1'b1, 4'd10); answer(1'b1, 4'd10);
        answer(1'b0, 4'd10);
        chk("mix_score", score_o, MIX_SCORE);
        chk("mix_done", done_o, 1);

        // saturation on the MAX_SCORE=100 instance
        pulse_start();
        for (int i = 0; i < 6; i++) answer(1'b1, 4'd15);
        chk("sat6_score", score2_o, 90);
        answer(1'b1, 4'd15);
        chk("sat7_score", score2_o, 100);
        for (int i = 0; i < 3; i++) answer(1'b1, 4'd15);
        chk("sat10_score", score2_o, 100);
        chk("sat10_done", done2_o, 1);
        chk("nosat_score", score_o, 150);

        // start collides with an answer mid-run
        pulse_start();
        for (int i = 0; i < 5; i++) answer(1'b1, 4'd9);
        chk("mid_score", score_o, 45);
        chk("mid_qcnt", q_count_o, 5);
        start_i = 1'b1;
        answer(1'b1, 4'd9);
        start_i = 1'b0;
        chk("restart_score", score_o, 0);
        chk("restart_qcnt", q_count_o, 0);
        chk("restart_busy", busy_o, 1);
        for (int i = 0; i < 10; i++) answer(1'b1, 4'd8);
        chk("rerun_score", score_o, 80);
        chk("rerun_done", done_o, 1);

        // answers in DONE are ignored
        for (int i = 0; i < 3; i++) answer(1'b1, 4'd15);
        chk("done_hold_score", score_o, 80);
        chk("done_hold_qcnt", q_count_o, 10);
        chk("done_hold_done", done_o, 1);

        reset_i = 1'b1;
        tick();
        chk("drst_score", score_o, 0);
        chk("drst_done", done_o, 0);
        chk("drst_clear", disp_clear_o, 1);
        chk("drst_en", disp_en_o, 0);
        reset_i = 1'b0;
        tick();
        chk("drst_en_back", disp_en_o, 1);

        // incorrect answers from zero never underflow
        pulse_start();
        for (int i = 0; i < 3; i++) answer(1'b0, 4'd5);
        chk("floor_score", score_o, 0);
        chk("floor_qcnt", q_count_o, 3);
        chk("floor_busy", busy_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quiz_score_accumulator.md
# quiz_score_accumulator

Sequential scoring stage that sits directly upstream of the 9-bit letter-grade seven-segment decoder. It collects a fixed-length run of graded answers, accumulates a 9-bit score, and drives the decoder's `score`, `en` and `clear` inputs. The decoder stays blank while a quiz is idle or in progress, and shows the grade only once the run completes.

## Interface
Parameters:
- `NUM_Q`, default 10: answers per quiz run, range 1..63.
- `MAX_SCORE`, default 511: saturation ceiling for `score`, must be ≤ 511.

Ports:
- `clk`  input  1  — single clock; all state changes on its rising edge.
- `reset`  input  1  — synchronous, active-high.
- `start`  input  1  — one-cycle pulse that begins or restarts a quiz run.
- `ans_valid`  input  1  — one-cycle strobe per answer; each high cycle counts as one answer.
- `ans_correct`  input  1  — qualifies `ans_valid`: answer was correct.
- `ans_pts`  input  4  — points awarded for a correct answer (0..15).
- `score`  output  9  — accumulated score, unsigned; connects to decoder `score`.
- `disp_en`  output  1  — connects to decoder `en`.
- `disp_clear`  output  1  — connects to decoder `clear`; 1 blanks the display.
- `busy`  output  1  — high in RUN.
- `done`  output  1  — high in DONE.
- `q_count`  output  6  — answers accepted in the current run.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset (any state, any cycle): state=IDLE, `score`=0, `q_count`=0, `busy`=0, `done`=0, `disp_clear`=1, `disp_en`=0.
- `disp_en` goes to 1 on the first clock after `reset` deasserts and then stays 1.
- IDLE: `disp_clear`=1, `ans_valid` is ignored. `start` → RUN, with `score`←0 and `q_count`←0.
- RUN: `busy`=1, `disp_clear`=1. On `ans_valid`:
  - `q_count` increments.
  - If `ans_correct`, `score`←min(`score`+`ans_pts`, `MAX_SCORE`).
  - When the accepted answer brings `q_count` to `NUM_Q` → DONE.
- DONE: `done`=1, `busy`=0, `disp_clear`=0. `score` and `q_count` hold. `ans_valid` is ignored. `start` → RUN with `score` and `q_count` cleared.
- `start` during RUN restarts the run: `score`←0, `q_count`←0, stay in RUN.
- `start` and `ans_valid` in the same cycle: `start` wins and the answer is discarded.
- Arithmetic: the sum is computed at 10 bits, then clamped to `MAX_SCORE`. `score` never wraps.
- Reset mid-RUN or mid-DONE: the partial score is discarded and the display blanks next cycle.

## Timing
- `score` and `q_count` update on the clock edge that samples `ans_valid`; they are visible the following cycle.
- The final answer's edge also registers the transition: `done`=1, `busy`=0 and `disp_clear`=0 appear together with the final `score`. No extra latency.
- `start` edge: `busy`=1 and `score`=0 are visible the next cycle, and `done` drops the same cycle.
- Back-to-back `ans_valid` on consecutive cycles is accepted at full rate (one answer per clock).
- Decoder output settles combinationally from the registered `score`/`disp_clear`, one cycle after the transition.

## Configuration
- `QUIZ_PENALTY_EN` defined:
  - An incorrect answer (`ans_valid`=1, `ans_correct`=0) subtracts 1 from `score`, floored at 0.
  - It still increments `q_count`.
- Not defined: an incorrect answer only increments `q_count`, and `score` is unchanged.
- The macro has no effect on ports, states or timing.

## Test plan
- Reset, then `start`, then 10 correct answers with `ans_pts`=9 (NUM_Q=10) → `score`=90, `done`=1, `disp_clear`=0 on the cycle after the 10th strobe; decoder shows "A".
- `start`, 6 correct ×10 pts and 4 incorrect → `score`=60 without the macro, 56 with `QUIZ_PENALTY_EN`; `done`=1 after the 10th answer.
- `start`, then 10 correct ×15 pts with `MAX_SCORE`=100 → `score` clamps at 100 from the 7th answer on; decoder shows "E".
- Mid-run (`q_count`=5, `score`=45): assert `start` together with `ans_valid` → next cycle `score`=0, `q_count`=0, `busy`=1, and the answer is not counted.
- In DONE, pulse `ans_valid` ×3 → `score` and `q_count` unchanged. Then assert `reset` → next cycle `score`=0, `done`=0, `disp_clear`=1, `disp_en`=0, and `disp_en`=1 one cycle after `reset` drops.
- With `QUIZ_PENALTY_EN`, `start` then 3 incorrect answers → `score` stays 0 (no underflow), `q_count`=3, `busy`=1.
